pdm_buffer_writer: RTL and testbench

- Write side of the PDM sample ring buffer.
- Accepts 64-bit PDM sample words on an AXI-Stream slave and stores them into a flattened PDM_BUFFER_WIDTH×PDM_DATA_WIDTH register array.
- The existing PDM sample multiplexer reads that array at its sample_select address.
- Tracks the reader's sample_select as the ring read pointer, never overwrites unread slots, and flags underruns.

---
 rtl/pdm_pkg.sv | 20 ++
 rtl/pdm_ring_ptr.sv | 40 ++++
 rtl/pdm_buffer_writer.sv | 160 ++++++++++++++++
 tb/tb_pdm_buffer_writer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM sample ring buffer: default geometry, writer
// state encoding and the slot-offset helper also used by the sample multiplexer.
package pdm_pkg;

  localparam int PDM_BUFFER_WIDTH_DEF        = 128;
  localparam int PDM_DATA_WIDTH_DEF          = 64;
  localparam int PDM_BUFFER_ADRESS_WIDTH_DEF = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2
  } pdm_state_e;

  // Bit offset of slot k inside the flattened buffer vector.
  function automatic int unsigned slot_offset(input int unsigned k, input int unsigned data_width);
    return k * data_width;
  endfunction

endpackage

// File: rtl/pdm_ring_ptr.sv
// Ring write pointer: aligns to the reader on start, advances per accepted word,
// and derives occupancy/full against the reader pointer (one guard slot).
module pdm_ring_ptr #(
  parameter int AW = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          align_i,
  input  logic          advance_i,
  input  logic [AW-1:0] rd_ptr_i,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] fill_o,
  output logic          full_o
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (align_i) begin
      wr_ptr_d = rd_ptr_i;
    end else if (advance_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Power-of-two ring: modular subtraction is the occupancy, all-ones is full.
  assign wr_ptr_o = wr_ptr_q;
  assign fill_o   = wr_ptr_q - rd_ptr_i;
  assign full_o   = &fill_o;

endmodule

// File: rtl/pdm_buffer_writer.sv
// Write side of the PDM sample ring buffer. Stats counters are built only when
// PDM_BUFFER_WRITER_STATS_EN is defined.
// Stream handshake: a word transfers on a cycle with s_axis_tvalid && s_axis_tready;
// tready depends only on writer state and buffer-full, never on tvalid.
module pdm_buffer_writer
  import pdm_pkg::*;
#(
  parameter int PDM_BUFFER_WIDTH        = PDM_BUFFER_WIDTH_DEF,
  parameter int PDM_DATA_WIDTH          = PDM_DATA_WIDTH_DEF,
  parameter int PDM_BUFFER_ADRESS_WIDTH = PDM_BUFFER_ADRESS_WIDTH_DEF,
  parameter int PREFILL_LEVEL           = 64
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic                                       enable,
  input  logic                                       clear,
  input  logic [PDM_DATA_WIDTH-1:0]                  s_axis_tdata,
  input  logic                                       s_axis_tvalid,
  output logic                                       s_axis_tready,
  input  logic [PDM_BUFFER_ADRESS_WIDTH-1:0]         sample_select,
  output logic [PDM_BUFFER_WIDTH*PDM_DATA_WIDTH-1:0] pdm_data_out,
  output logic [PDM_BUFFER_ADRESS_WIDTH-1:0]         wr_ptr,
  output logic [PDM_BUFFER_ADRESS_WIDTH-1:0]         fill_level,
  output logic                                       primed,
  output logic                                       underrun,
  output pdm_state_e                                 state_dbg
`ifdef PDM_BUFFER_WRITER_STATS_EN
  ,
  output logic [31:0]                                sample_count,
  output logic [15:0]                                underrun_count
`endif
);

  localparam int AW = PDM_BUFFER_ADRESS_WIDTH;
  localparam int DW = PDM_DATA_WIDTH;
  localparam int NB = PDM_BUFFER_WIDTH;
  localparam int FILL_W = AW + 1;
  localparam logic [FILL_W-1:0] PRIME_AT = FILL_W'(PREFILL_LEVEL);

  pdm_state_e state_q, state_d;
  logic primed_q, primed_d;
  logic underrun_q, underrun_d;
  logic [AW-1:0] fill, fill_level_q, sel_q;
  logic full, align, wr_fire, underrun_evt;
  logic [FILL_W-1:0] fill_post;
  logic [DW-1:0] slot_q [NB];

  pdm_ring_ptr #(.AW(AW)) u_ring_ptr (
    .clk_i     (aclk),
    .rst_i     (areset),
    .align_i   (align),
    .advance_i (wr_fire),
    .rd_ptr_i  (sample_select),
    .wr_ptr_o  (wr_ptr),
    .fill_o    (fill),
    .full_o    (full)
  );

  assign s_axis_tready = (state_q != IDLE) && !full;
  assign wr_fire       = s_axis_tvalid && s_axis_tready;
  assign fill_post     = {1'b0, fill} + FILL_W'(wr_fire);

  // Reader moved while the buffer was already empty last cycle.
  assign underrun_evt = (state_q == RUN) && (sample_select != sel_q) && (fill_level_q == '0);
  assign underrun_d   = underrun_evt ? 1'b1 : (clear ? 1'b0 : underrun_q);

  always_comb begin
    state_d  = state_q;
    primed_d = primed_q;
    align    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          align    = 1'b1;
          primed_d = 1'b0;
          state_d  = PREFILL;
        end
      end
      PREFILL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (fill_post >= PRIME_AT) begin
          primed_d = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      primed_q     <= 1'b0;
      underrun_q   <= 1'b0;
      fill_level_q <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      primed_q     <= primed_d;
      underrun_q   <= underrun_d;
      fill_level_q <= fill;
      sel_q        <= sample_select;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < NB; k++) begin
        slot_q[k] <= '0;
      end
    end else if (wr_fire) begin
      slot_q[wr_ptr] <= s_axis_tdata;
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_flat
    assign pdm_data_out[slot_offset(k, DW) +: DW] = slot_q[k];
  end

  assign fill_level = fill_level_q;
  assign primed     = primed_q;
  assign underrun   = underrun_q;
  assign state_dbg  = state_q;

`ifdef PDM_BUFFER_WRITER_STATS_EN
  logic [31:0] sample_count_q, sample_count_d;
  logic [15:0] underrun_count_q, underrun_count_d;

  // A clear coinciding with an event restarts the count at that event.
  always_comb begin
    sample_count_d   = clear ? 32'(wr_fire) : sample_count_q + 32'(wr_fire);
    underrun_count_d = underrun_count_q;
    if (clear) begin
      underrun_count_d = 16'(underrun_evt);
    end else if (underrun_evt && (underrun_count_q != 16'hFFFF)) begin
      underrun_count_d = underrun_count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sample_count_q   <= '0;
      underrun_count_q <= '0;
    end else begin
      sample_count_q   <= sample_count_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign sample_count   = sample_count_q;
  assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_pdm_buffer_writer.sv
// Self-checking bench for pdm_buffer_writer: directed table, test-plan sequences
// and randomized traffic against a ring-buffer reference model.
module tb_pdm_buffer_writer;
  import pdm_pkg::*;

  localparam int NB = 128;
  localparam int DW = 64;
  localparam int AW = 7;
  localparam int PL = 64;

  logic aclk = 1'b0;
  logic areset, enable, clear, s_axis_tvalid, s_axis_tready, primed, underrun;
  logic [DW-1:0] s_axis_tdata;
  logic [AW-1:0] sample_select, wr_ptr, fill_level;
  logic [NB*DW-1:0] pdm_data_out;
  pdm_state_e state_dbg;
`ifdef PDM_BUFFER_WRITER_STATS_EN
  logic [31:0] sample_count;
  logic [15:0] underrun_count;
`endif

  pdm_buffer_writer dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .clear         (clear),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .sample_select (sample_select),
    .pdm_data_out  (pdm_data_out),
    .wr_ptr        (wr_ptr),
    .fill_level    (fill_level),
    .primed        (primed),
    .underrun      (underrun),
    .state_dbg     (state_dbg)
`ifdef PDM_BUFFER_WRITER_STATS_EN
    ,
    .sample_count  (sample_count),
    .underrun_count(underrun_count)
`endif
  );

  always #5 aclk = ~aclk;

  // Reference model: ring contents, write position, run/primed flags.
  logic [DW-1:0] m_mem [NB];
  int m_wr, m_prev_fill, m_prev_sel;
  bit m_on, m_primed, m_underrun;
  bit last_fire, last_rdy_act;
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    bit         en;
    bit         vld;
    logic [6:0] sel;
    bit         exp_rdy;
    logic [6:0] exp_wr;
    logic [6:0] exp_fl;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot(input int k);
    return pdm_data_out[k*DW +: DW];
  endfunction

  function automatic int mfill(input int sel);
    return (m_wr - sel + NB) % NB;
  endfunction

  task automatic check_buf();
    int bad;
    bad = -1;
    for (int k = 0; k < NB; k++) begin
      if (bad < 0 && slot(k) !== m_mem[k]) bad = k;
    end
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL buffer slot %0d: got %0h expected %0h", bad, slot(bad), m_mem[bad]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB; k++) m_mem[k] = '0;
    m_wr = 0; m_prev_fill = 0; m_prev_sel = 0;
    m_on = 0; m_primed = 0; m_underrun = 0;
  endtask

  task automatic do_reset(input logic [6:0] sel);
    sample_select = sel;
    enable = 0; s_axis_tvalid = 0; clear = 0; s_axis_tdata = '0;
    areset = 1;
    #1;
    check("rst_tready", 64'(s_axis_tready), 64'(0));
    check("rst_wr_ptr", 64'(wr_ptr), 64'(0));
    check("rst_fill_level", 64'(fill_level), 64'(0));
    check("rst_primed", 64'(primed), 64'(0));
    check("rst_underrun", 64'(underrun), 64'(0));
    check("rst_buffer_zero", 64'(pdm_data_out == '0), 64'(1));
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    @(posedge aclk);
    #1;
    areset = 0;
    model_reset();
  endtask

  // One clock: drive, check tready before the edge, then registered outputs after it.
  task automatic cycle(input bit en, input bit vld, input logic [DW-1:0] data,
                       input logic [6:0] sel, input bit clr);
    int f;
    bit rdy, ev;
    enable = en; s_axis_tvalid = vld; s_axis_tdata = data;
    sample_select = sel; clear = clr;
    #1;
    f = mfill(int'(sel));
    rdy = m_on && (f != NB - 1);
    last_rdy_act = s_axis_tready;
    check("tready", 64'(s_axis_tready), 64'(rdy));
    last_fire = vld && rdy;
    ev = m_on && m_primed && (int'(sel) != m_prev_sel) && (m_prev_fill == 0);
    if (last_fire) begin
      m_mem[m_wr] = data;
      m_wr = (m_wr + 1) % NB;
    end
    if (!m_on) begin
      if (en) begin
        m_on = 1; m_primed = 0; m_wr = int'(sel);
      end
    end else if (!en) begin
      m_on = 0;
    end else if (!m_primed && (f + int'(last_fire)) >= PL) begin
      m_primed = 1;
    end
    m_underrun = ev ? 1'b1 : (clr ? 1'b0 : m_underrun);
    m_prev_fill = f;
    m_prev_sel = int'(sel);
    @(posedge aclk);
    #1;
    check("wr_ptr", 64'(wr_ptr), 64'(m_wr));
    check("fill_level", 64'(fill_level), 64'(m_prev_fill));
    check("primed", 64'(primed), 64'(m_primed));
    check("underrun", 64'(underrun), 64'(m_underrun));
    check_buf();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [6:0] rsel;
    logic [DW-1:0] w;

    tbl[0] = '{1'b0, 1'b1, 7'd5,  1'b0, 7'd0,  7'd123};
    tbl[1] = '{1'b1, 1'b1, 7'd5,  1'b0, 7'd5,  7'd123};
    tbl[2] = '{1'b1, 1'b1, 7'd5,  1'b1, 7'd6,  7'd0};
    tbl[3] = '{1'b1, 1'b1, 7'd5,  1'b1, 7'd7,  7'd1};
    tbl[4] = '{1'b1, 1'b0, 7'd6,  1'b1, 7'd7,  7'd1};
    tbl[5] = '{1'b0, 1'b1, 7'd6,  1'b1, 7'd8,  7'd1};
    tbl[6] = '{1'b0, 1'b1, 7'd6,  1'b0, 7'd8,  7'd2};
    tbl[7] = '{1'b1, 1'b0, 7'd20, 1'b0, 7'd20, 7'd116};
    tbl[8] = '{1'b1, 1'b1, 7'd20, 1'b1, 7'd21, 7'd0};

    do_reset(7'd5);
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].en, tbl[i].vld, 64'hA0 + 64'(i), tbl[i].sel, 1'b0);
      check("tbl_tready", 64'(last_rdy_act), 64'(tbl[i].exp_rdy));
      check("tbl_wr_ptr", 64'(wr_ptr), 64'(tbl[i].exp_wr));
      check("tbl_fill_level", 64'(fill_level), 64'(tbl[i].exp_fl));
    end

    // Prefill from slot 10 with words 0x1..0x40.
    do_reset(7'd10);
    cycle(1, 0, '0, 7'd10, 0);
    check("t1_align", 64'(wr_ptr), 64'(10));
    acc = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1, 1, 64'(i + 1), 7'd10, 0);
      check("t1_tready_high", 64'(last_rdy_act), 64'(1));
      if (last_fire) begin exp_q.push_back(64'(i + 1)); acc++; end
      if (i == 62) check("t1_not_primed_yet", 64'(primed), 64'(0));
    end
    check("t1_primed", 64'(primed), 64'(1));
    check("t1_slot10", slot(10), 64'h1);
    check("t1_slot73", slot(73), 64'h40);

    // Stream into a fixed reader until full.
    for (int i = 0; i < 200; i++) begin
      w = 64'(acc + 1);
      cycle(1, 1, w, 7'd10, 0);
      if (last_fire) begin exp_q.push_back(w); acc++; end
    end
    check("t2_accepted", 64'(acc), 64'(127));
    check("t2_wr_ptr", 64'(wr_ptr), 64'(9));
    check("t2_tready_full", 64'(s_axis_tready), 64'(0));
    check("t2_fill_level", 64'(fill_level), 64'(127));
    for (int k = 0; k < 127; k++) begin
      w = exp_q.pop_front();
      check("t2_scoreboard", slot((10 + k) % NB), w);
    end
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reader advance at full reopens the guard slot in the same cycle.
    cycle(1, 1, 64'hBEEF, 7'd11, 0);
    check("t3_tready_reopen", 64'(last_rdy_act), 64'(1));
    check("t3_wr_ptr", 64'(wr_ptr), 64'(10));
    check("t3_slot9", slot(9), 64'hBEEF);
    check("t3_slot10_kept", slot(10), 64'h1);

    // Wrap around the top of the ring.
    cycle(0, 0, '0, 7'd11, 0);
    cycle(1, 0, '0, 7'd120, 0);
    check("t4_align", 64'(wr_ptr), 64'(120));
    for (int i = 0; i < 16; i++) cycle(1, 1, 64'h200 + 64'(i), 7'd120, 0);
    check("t4_wr_ptr", 64'(wr_ptr), 64'(8));
    check("t4_slot120", slot(120), 64'h200);
    check("t4_slot127", slot(127), 64'h207);
    check("t4_slot0", slot(0), 64'h208);
    check("t4_slot7", slot(7), 64'h20F);
    check("t4_not_primed", 64'(primed), 64'(0));

    // Reach RUN, drain by jumping the reader, then provoke underruns.
    for (int i = 0; i < 48; i++) cycle(1, 1, 64'h300 + 64'(i), 7'd120, 0);
    check("t5_primed", 64'(primed), 64'(1));
    check("t5_wr_ptr", 64'(wr_ptr), 64'(56));
    cycle(1, 0, '0, 7'd56, 0);
    check("t5_no_underrun", 64'(underrun), 64'(0));
    cycle(1, 0, '0, 7'd57, 0);
    check("t5_underrun_set", 64'(underrun), 64'(1));
    cycle(1, 0, '0, 7'd57, 1);
    check("t5_underrun_clear", 64'(underrun), 64'(0));
    cycle(1, 0, '0, 7'd56, 0);
    cycle(1, 0, '0, 7'd57, 1);
    check("t5_clear_vs_event", 64'(underrun), 64'(1));

    // Asynchronous reset mid-stream.
    cycle(0, 0, '0, 7'd57, 0);
    cycle(1, 0, '0, 7'd0, 0);
    for (int i = 0; i < 50; i++) cycle(1, 1, {$urandom, $urandom}, 7'd0, 0);
    check("t6_wr_ptr", 64'(wr_ptr), 64'(50));
    do_reset(7'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 64'h55, 7'd0, 0);
      check("t6_tready_idle", 64'(last_rdy_act), 64'(0));
    end
    cycle(1, 1, 64'h66, 7'd0, 0);
    check("t6_tready_enable_cycle", 64'(last_rdy_act), 64'(0));
    cycle(1, 1, 64'h77, 7'd0, 0);
    check("t6_tready_after_enable", 64'(last_rdy_act), 64'(1));

    // Randomized traffic: writer-heavy then reader-heavy.
    rsel = 7'd0;
    for (int i = 0; i < 1600; i++) begin
      int r;
      bit en, vld, clr;
      r = $urandom_range(0, 99);
      if (r < 40) rsel = rsel + 7'd1;
      else if (r < 43) rsel = 7'($urandom_range(0, 127));
      en  = ($urandom_range(0, 99) < 96);
      vld = (i < 800) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 19) == 0);
      cycle(en, vld, {$urandom, $urandom}, rsel, clr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
